code_lock: RTL and testbench

Multi-digit, parametrised successor to the single-digit confirm-key safe controller. It accepts a code of CODE_LEN digits entered one at a time on switches and confirmed by a push key. It compares the code against a parameter password and drives the pass/fail lamps, a remaining-tries count and an entry-progress count. It sits between the board push keys/switches and the lamp and 7-segment decode logic.

---
 rtl/code_lock_pkg.sv | 18 +
 rtl/code_lock_if.sv | 25 ++
 rtl/key_pulse_filter.sv | 56 +++++
 rtl/code_lock.sv | 172 +++++++++++++++++
 tb/tb_code_lock.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/code_lock_pkg.sv
// code_lock_pkg: shared types and constants for the multi-digit code lock.
// FSM state encoding and active-low lamp patterns driven onto led[1:0].
package code_lock_pkg;

    typedef enum logic [1:0] {
        ENTRY  = 2'd0,
        CHECK  = 2'd1,
        OPEN   = 2'd2,
        LOCKED = 2'd3
    } state_e;

    // led[1] = green (open), led[0] = red (wrong/locked); lamps are active-low
    localparam logic [1:0] LED_OFF   = 2'b11;
    localparam logic [1:0] LED_GREEN = 2'b01;
    localparam logic [1:0] LED_RED   = 2'b10;
    localparam logic [1:0] LED_BOTH  = 2'b00;

endpackage

// File: rtl/code_lock_if.sv
// code_lock_if: board-side signals of the code lock.
// The master drives the raw keys and switches; the slave (the lock) drives
// the lamps and the status counters.
interface code_lock_if #(
    parameter int DIGIT_W = 4
);
    logic               key;
    logic               key_clr;
    logic [DIGIT_W-1:0] sw_digit;
    logic [1:0]         led;
    logic [3:0]         tries_left;
    logic [2:0]         digit_cnt;
    logic               unlocked;
    logic               locked_out;

    modport master (
        output key, key_clr, sw_digit,
        input  led, tries_left, digit_cnt, unlocked, locked_out
    );

    modport slave (
        input  key, key_clr, sw_digit,
        output led, tries_left, digit_cnt, unlocked, locked_out
    );
endinterface

// File: rtl/key_pulse_filter.sv
// key_pulse_filter: synchronises an active-low raw key, debounces it and
// emits a single-cycle pulse on each debounced high-to-low transition.
// The pulse register rises DEBOUNCE_CYCLES+3 clocks after the raw level
// settles low: two synchroniser stages, then DEBOUNCE_CYCLES+1 stable samples.
module key_pulse_filter #(
    parameter int DEBOUNCE_CYCLES = 262143
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pulse
);
    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive samples differing from the accepted level; any bounce restarts it
    always_comb begin
        sync1_d  = key_n;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        pulse_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                stable_d = sync2_q;
                pulse_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Filter state; idle level is "key released" (high)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pulse = pulse_q;
endmodule

// File: rtl/code_lock.sv
// code_lock: multi-digit code lock with confirm/clear keys, limited tries
// and a lockout state.
// Optional feature macro: CODE_LOCK_LOCKOUT_EN -- when defined, LOCKED
// expires after LOCKOUT_CYCLES clocks; otherwise LOCKED holds until rst.
module code_lock #(
    parameter int                        DIGIT_W         = 4,
    parameter int                        CODE_LEN        = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] PASSWORD      = 16'h1234,
    parameter int                        MAX_TRIES       = 3,
    parameter int                        DEBOUNCE_CYCLES = 262143,
    parameter int                        LOCKOUT_CYCLES  = 12000000
) (
    input logic       clk,
    input logic       rst,
    code_lock_if.slave bus
);
    import code_lock_pkg::*;

    localparam int         CODE_W   = CODE_LEN * DIGIT_W;
    localparam logic [2:0] LAST_IDX = 3'(CODE_LEN - 1);
    localparam logic [3:0] TRIES0   = 4'(MAX_TRIES);

    if (CODE_LEN < 1 || CODE_LEN > 8 || MAX_TRIES < 1 || MAX_TRIES > 15 ||
        LOCKOUT_CYCLES < 1) begin : g_bad_params
        $error("code_lock: parameter out of range");
    end

    // Index 0 = confirm key, index 1 = clear key
    logic [1:0] raw_keys;
    logic [1:0] key_pulses;
    logic       cfm_pulse, clr_pulse;

    assign raw_keys  = {bus.key_clr, bus.key};
    assign cfm_pulse = key_pulses[0];
    assign clr_pulse = key_pulses[1];

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_filt
        key_pulse_filter #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_filt (
            .clk   (clk),
            .rst   (rst),
            .key_n (raw_keys[gi]),
            .pulse (key_pulses[gi])
        );
    end

    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [3:0]        tries_q, tries_d;
    logic [1:0]        led_q, led_d;
    logic              unlocked_q, unlocked_d;
    logic              locked_out_q, locked_out_d;

`ifdef CODE_LOCK_LOCKOUT_EN
    localparam int LCW = (LOCKOUT_CYCLES < 2) ? 1 : $clog2(LOCKOUT_CYCLES);
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
`endif

    // Next-state and registered-output logic; clear always beats confirm
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        cnt_d        = cnt_q;
        tries_d      = tries_q;
        led_d        = led_q;
        unlocked_d   = unlocked_q;
        locked_out_d = locked_out_q;
`ifdef CODE_LOCK_LOCKOUT_EN
        lock_cnt_d   = lock_cnt_q;
`endif
        case (state_q)
            ENTRY: begin
                if (clr_pulse) begin
                    cnt_d  = '0;
                    code_d = '0;
                    led_d  = LED_OFF;
                end else if (cfm_pulse) begin
                    code_d = (code_q << DIGIT_W) | CODE_W'(bus.sw_digit);
                    // digit_cnt holds at the last index through CHECK
                    if (cnt_q == LAST_IDX) begin
                        state_d = CHECK;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            CHECK: begin
                cnt_d  = '0;
                code_d = '0;
                if (code_q == PASSWORD) begin
                    state_d    = OPEN;
                    led_d      = LED_GREEN;
                    unlocked_d = 1'b1;
                end else if (tries_q > 4'd1) begin
                    state_d = ENTRY;
                    tries_d = tries_q - 4'd1;
                    led_d   = LED_RED;
                end else begin
                    state_d      = LOCKED;
                    tries_d      = '0;
                    led_d        = LED_BOTH;
                    locked_out_d = 1'b1;
`ifdef CODE_LOCK_LOCKOUT_EN
                    lock_cnt_d   = LCW'(LOCKOUT_CYCLES - 1);
`endif
                end
            end
            OPEN: begin
                if (clr_pulse) begin
                    state_d    = ENTRY;
                    tries_d    = TRIES0;
                    led_d      = LED_OFF;
                    unlocked_d = 1'b0;
                end
            end
            LOCKED: begin
`ifdef CODE_LOCK_LOCKOUT_EN
                if (lock_cnt_q == '0) begin
                    state_d      = ENTRY;
                    tries_d      = TRIES0;
                    led_d        = LED_OFF;
                    locked_out_d = 1'b0;
                end else begin
                    lock_cnt_d = lock_cnt_q - 1'b1;
                end
`endif
            end
            default: state_d = ENTRY;
        endcase
    end

    // FSM state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ENTRY;
            code_q       <= '0;
            cnt_q        <= '0;
            tries_q      <= TRIES0;
            led_q        <= LED_OFF;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            cnt_q        <= cnt_d;
            tries_q      <= tries_d;
            led_q        <= led_d;
            unlocked_q   <= unlocked_d;
            locked_out_q <= locked_out_d;
        end
    end

`ifdef CODE_LOCK_LOCKOUT_EN
    // Lockout down-counter, loaded on entry to LOCKED
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`endif

    assign bus.led        = led_q;
    assign bus.tries_left = tries_q;
    assign bus.digit_cnt  = cnt_q;
    assign bus.unlocked   = unlocked_q;
    assign bus.locked_out = locked_out_q;
endmodule

// File: tb/tb_code_lock.sv
// tb_code_lock: randomized + directed bench for code_lock with a scoreboard.
// Stimulus updates a digit-list reference model and queues the expected
// output tuple; a monitor pops an entry on every change of the DUT outputs.
module tb_code_lock;
    localparam int          DIGIT_W  = 4;
    localparam int          CODE_LEN = 4;
    localparam logic [15:0] PASSWORD = 16'h1234;
    localparam int          MAX_TRIES = 3;
    localparam int          DEB      = 4;
    localparam int          LOCK     = 20;

    typedef struct packed {
        logic [1:0] led;
        logic [3:0] tries;
        logic [2:0] dcnt;
        logic       unl;
        logic       lo;
    } outs_t;

    typedef struct {
        outs_t o;
        int    at_cyc;   // absolute cycle of the change, -1 = any
        int    gap;      // cycles since previous change, -1 = any
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];

    // Reference model state
    int       m_digits[$];
    int       m_tries;
    bit       m_open, m_locked;
    logic [1:0] m_led;
    outs_t    m_last;

    code_lock_if #(.DIGIT_W(DIGIT_W)) bus ();

    code_lock #(
        .DIGIT_W(DIGIT_W), .CODE_LEN(CODE_LEN), .PASSWORD(PASSWORD),
        .MAX_TRIES(MAX_TRIES), .DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(LOCK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic outs_t outs_now();
        outs_t o;
        o.led = bus.led; o.tries = bus.tries_left; o.dcnt = bus.digit_cnt;
        o.unl = bus.unlocked; o.lo = bus.locked_out;
        return o;
    endfunction

    function automatic outs_t model_outs();
        outs_t o;
        o.led = m_led; o.tries = 4'(m_tries); o.dcnt = 3'(m_digits.size());
        o.unl = m_open; o.lo = m_locked;
        return o;
    endfunction

    function automatic string fmt(outs_t o);
        return $sformatf("led=%b tries=%0d dcnt=%0d unl=%b lo=%b",
                         o.led, o.tries, o.dcnt, o.unl, o.lo);
    endfunction

    task automatic check(input bit ok, input string name, input string act, input string req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, expected %s", name, act, req);
    endtask

    task automatic push_exp(input int at, input int gap);
        exp_t e;
        outs_t o;
        o = model_outs();
        if (o != m_last) begin
            e.o = o; e.at_cyc = at; e.gap = gap;
            exp_q.push_back(e);
            m_last = o;
        end
    endtask

    function automatic void model_reset();
        m_digits.delete();
        m_tries = MAX_TRIES; m_open = 0; m_locked = 0; m_led = 2'b11;
    endfunction

    function automatic void model_confirm(input int d);
        int unsigned v;
        if (m_open || m_locked) return;
        m_digits.push_back(d);
        if (m_digits.size() < CODE_LEN) return;
        v = 0;
        foreach (m_digits[i]) v = v * (2 ** DIGIT_W) + m_digits[i];
        m_digits.delete();
        if (v == PASSWORD) begin
            m_open = 1; m_led = 2'b01;
        end else if (m_tries > 1) begin
            m_tries--; m_led = 2'b10;
        end else begin
            m_tries = 0; m_locked = 1; m_led = 2'b00;
        end
    endfunction

    function automatic void model_clear();
        if (m_locked) return;
        if (m_open) begin
            m_open = 0; m_tries = MAX_TRIES;
        end
        m_digits.delete();
        m_led = 2'b11;
    endfunction

    function automatic int pw_digit(input int p);
        logic [15:0] pw;
        pw = PASSWORD;
        return int'((pw >> (DIGIT_W * (CODE_LEN - 1 - p))) & 16'hF);
    endfunction

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One key press (confirm, clear, or both together), held then released
    task automatic press(input bit cfm, input bit clr, input int digit);
        bit was_locked;
        bit became_locked;
        was_locked = m_locked;
        @(negedge clk);
        bus.sw_digit = 4'(digit);
        if (cfm) bus.key = 1'b0;
        if (clr) bus.key_clr = 1'b0;
        if (clr) model_clear();
        else if (cfm) model_confirm(digit);
        push_exp(-1, -1);
        became_locked = !was_locked && m_locked;
`ifdef CODE_LOCK_LOCKOUT_EN
        if (became_locked) begin
            m_locked = 0; m_tries = MAX_TRIES; m_led = 2'b11;
            push_exp(-1, LOCK);
        end
`endif
        wait_neg(DEB + 6);
        bus.key = 1'b1;
        bus.key_clr = 1'b1;
        wait_neg(DEB + 6);
        if (became_locked) wait_neg(LOCK + 5);
    endtask

    task automatic enter_code(input int d0, input int d1, input int d2, input int d3);
        press(1, 0, d0); press(1, 0, d1); press(1, 0, d2); press(1, 0, d3);
    endtask

    // Asynchronous reset pulse; outputs must reach reset values before the next edge
    task automatic do_reset();
        outs_t rv;
        rv = '{led: 2'b11, tries: 4'(MAX_TRIES), dcnt: 3'd0, unl: 1'b0, lo: 1'b0};
        @(negedge clk);
        model_reset();
        push_exp(-1, -1);
        #2 rst = 1'b1;
        #1 check(outs_now() === rv, "rst_async", fmt(outs_now()), fmt(rv));
        wait_neg(2);
        rst = 1'b0;
    endtask

    // Scoreboard monitor: every output change consumes one expected entry
    initial begin
        outs_t cur, prev;
        exp_t  e;
        int    last_evt;
        last_evt = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = outs_now();
            if (mon_en && cur !== prev) begin
                check(exp_q.size() != 0, "unexpected_change", fmt(cur), "no change");
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    $display("event cyc=%0d %s", cyc, fmt(cur));
                    check(cur === e.o, "outputs", fmt(cur), fmt(e.o));
                    if (e.at_cyc >= 0)
                        check(cyc == e.at_cyc, "pulse_cycle",
                              $sformatf("%0d", cyc), $sformatf("%0d", e.at_cyc));
                    if (e.gap >= 0)
                        check(cyc - last_evt == e.gap, "lockout_cycles",
                              $sformatf("%0d", cyc - last_evt), $sformatf("%0d", e.gap));
                end
                last_evt = cyc;
            end
            prev = cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        outs_t rv;
        int settle;
        int r, d;
        bus.key = 1'b1;
        bus.key_clr = 1'b1;
        bus.sw_digit = '0;
        rv = '{led: 2'b11, tries: 4'(MAX_TRIES), dcnt: 3'd0, unl: 1'b0, lo: 1'b0};
        wait_neg(3);
        check(outs_now() === rv, "reset_state", fmt(outs_now()), fmt(rv));
        rst = 1'b0;
        model_reset();
        m_last = model_outs();
        mon_en = 1'b1;
        wait_neg(2);

        // Correct code opens, clear relocks
        enter_code(1, 2, 3, 4);
        press(0, 1, 0);

        // Bouncing confirm key: one pulse timed from the final settle
        @(negedge clk);
        bus.sw_digit = 4'd1;
        for (int i = 0; i < 4; i++) begin
            bus.key = (i % 2 == 1);
            wait_neg(2);
        end
        bus.key = 1'b0;
        settle = cyc;
        model_confirm(1);
        push_exp(settle + DEB + 4, -1);
        wait_neg(DEB + 8);
        bus.key = 1'b1;
        wait_neg(DEB + 6);

        // Partial entry, clear, then full correct code
        press(1, 0, 2);
        press(0, 1, 0);
        enter_code(1, 2, 3, 4);
        press(0, 1, 0);

        // Confirm and clear in the same cycle: clear wins
        press(1, 0, 5);
        press(1, 1, 7);

        // Three wrong codes lead to LOCKED
        for (int t = 0; t < 3; t++) enter_code(0, 0, 0, 0);
`ifndef CODE_LOCK_LOCKOUT_EN
        press(1, 0, 1);
        press(0, 1, 0);
        wait_neg(100);
        check(bus.locked_out === 1'b1 && bus.led === 2'b00, "lock_permanent",
              fmt(outs_now()), "led=00 lo=1");
        do_reset();
`endif

        // Reset mid-entry and while open
        press(1, 0, 1);
        press(1, 0, 2);
        do_reset();
        enter_code(1, 2, 3, 4);
        do_reset();

        // Randomized actions
        for (int n = 0; n < 40; n++) begin
            if (m_locked) do_reset();
            r = $urandom_range(0, 11);
            if (r <= 6) begin
                d = ($urandom_range(0, 2) != 0) ? pw_digit(m_digits.size())
                                                : int'($urandom_range(0, 15));
                press(1, 0, d);
            end else if (r <= 8) begin
                press(0, 1, 0);
            end else if (r == 9) begin
                press(1, 1, int'($urandom_range(0, 15)));
            end else begin
                do_reset();
            end
        end

        wait_neg(LOCK + 20);
        check(exp_q.size() == 0, "queue_drained",
              $sformatf("%0d pending", exp_q.size()), "0 pending");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
